// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM state encoding,
// grant-source encoding and the latency-counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } mem_arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_src_e;

  // Counter must hold MEM_LAT itself; never narrower than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter used to time one memory access; flags zero and the
// final counting cycle (count == 1) so the owner can capture on the next edge.
module arb_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between IF and MEM stages.
// Optional MEM_ARB_PERF_EN adds saturating per-stage stall-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              if_stall,
  output logic              mem_stall,
  output mem_arb_state_e    dbg_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_mem_stall
`endif
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);

  mem_arb_state_e    state_q, state_d;
  gnt_src_e          gnt;
  logic              m_en_q, m_en_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              cnt_zero, cnt_last, cnt_dec;

  assign cnt_dec = (state_q != IDLE) && !cnt_zero;

  arb_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gnt != GNT_NONE),
    .load_val (CNT_W'(MEM_LAT)),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    gnt         = GNT_NONE;
    m_en_d      = 1'b0;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    // A requester whose done pulse is visible this cycle is not re-granted,
    // which hands the next slot to the other stage.
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_done_q) begin
          gnt = GNT_MEM;
        end else if (if_req && !if_done_q) begin
          gnt = GNT_IF;
        end
      end
      BUSY_IF: begin
        if (cnt_last) begin
          if_rdata_d = m_rdata;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY_MEM: begin
        if (cnt_last) begin
          if (!m_wr_q) begin
            mem_rdata_d = m_rdata;
          end
          mem_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (gnt)
      GNT_MEM: begin
        state_d   = BUSY_MEM;
        m_en_d    = 1'b1;
        m_wr_d    = mem_wr;
        m_addr_d  = mem_addr;
        m_wdata_d = mem_wdata;
      end
      GNT_IF: begin
        state_d  = BUSY_IF;
        m_en_d   = 1'b1;
        m_wr_d   = 1'b0;
        m_addr_d = if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_en_q      <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_en_q      <= m_en_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign m_en      = m_en_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_stall  = if_req & ~if_done_q;
  assign mem_stall = mem_req & ~mem_done_q;
  assign dbg_state = state_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  always_comb begin
    perf_if_d  = perf_if_q;
    perf_mem_d = perf_mem_q;
    if (if_stall && (perf_if_q != 32'hFFFF_FFFF)) begin
      perf_if_d = perf_if_q + 32'd1;
    end
    if (mem_stall && (perf_mem_q != 32'hFFFF_FFFF)) begin
      perf_mem_d = perf_mem_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_if_q  <= perf_if_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign perf_if_stall  = perf_if_q;
  assign perf_mem_stall = perf_mem_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=4) with a behavioural memory whose
// read data is valid only in the single cycle the arbiter is due to capture it.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_wr;
  logic [15:0] if_addr, mem_addr, mem_wdata, m_rdata;
  logic        m_en, m_wr, if_done, mem_done, if_stall, mem_stall;
  logic [15:0] m_addr, m_wdata, if_rdata, mem_rdata;
  mem_arb_state_e dbg_state;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall, perf_mem_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .m_rdata   (m_rdata),
    .m_en      (m_en),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .if_stall  (if_stall),
    .mem_stall (mem_stall),
    .dbg_state (dbg_state)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_stall  (perf_if_stall),
    .perf_mem_stall (perf_mem_stall)
`endif
  );

  // Behavioural memory: unwritten words read as addr ^ 16'h5A5A.
  logic [15:0] wmem [logic [15:0]];
  logic        p0_v = 1'b0, p1_v = 1'b0, p2_v = 1'b0;
  logic [15:0] p0_d, p1_d, p2_d;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    p0_v <= m_en;
    p0_d <= mem_val(m_addr);
    p1_v <= p0_v;
    p1_d <= p0_d;
    p2_v <= p1_v;
    p2_d <= p1_d;
    if (m_en && m_wr) wmem[m_addr] = m_wdata;
  end

  assign m_rdata = p2_v ? p2_d : 16'hxxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cycle0();
    @(negedge clk);
    cyc = 0;
  endtask

  task automatic to_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_en", m_en, 0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_outs", {m_wr, if_done, mem_done, m_addr}, 0);
    rst_n = 1'b1;

    // Simultaneous requests: data access first, fetch follows.
    start_cycle0();
    if_req = 1'b1; if_addr = 16'h0050;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0100;
    #1;
    chk("s2_if_stall_c0", if_stall, 1);
    chk("s2_mem_stall_c0", mem_stall, 1);
    to_cyc(1);
    chk("s2_m_en_c1", m_en, 1);
    chk("s2_m_addr_c1", m_addr, 16'h0100);
    chk("s2_state_c1", dbg_state, BUSY_MEM);
    to_cyc(4);
    chk("s2_mem_done_c4", mem_done, 0);
    to_cyc(5);
    chk("s2_mem_done_c5", mem_done, 1);
    chk("s2_mem_rdata_c5", mem_rdata, 16'h5B5A);
    chk("s2_mem_stall_c5", mem_stall, 0);
    chk("s2_if_stall_c5", if_stall, 1);
    mem_req = 1'b0;
    to_cyc(6);
    chk("s2_fetch_m_en_c6", m_en, 1);
    chk("s2_fetch_addr_c6", m_addr, 16'h0050);
    chk("s2_fetch_wr_c6", m_wr, 0);
    to_cyc(9);
    chk("s2_if_done_c9", if_done, 0);
    to_cyc(10);
    chk("s2_if_done_c10", if_done, 1);
    chk("s2_if_rdata_c10", if_rdata, 16'h5A0A);
`ifdef MEM_ARB_PERF_EN
    chk("s2_perf_mem", perf_mem_stall, 5);
    chk("s2_perf_if", perf_if_stall, 10);
`endif
    if_req = 1'b0;
    to_cyc(11);
    chk("s2_if_done_c11", if_done, 0);

    // Single fetch.
    start_cycle0();
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    chk("s1_if_stall_c0", if_stall, 1);
    to_cyc(1);
    chk("s1_m_en_c1", m_en, 1);
    chk("s1_m_wr_c1", m_wr, 0);
    chk("s1_m_addr_c1", m_addr, 16'h0010);
    to_cyc(2);
    chk("s1_m_en_c2", m_en, 0);
    to_cyc(4);
    chk("s1_if_stall_c4", if_stall, 1);
    chk("s1_if_done_c4", if_done, 0);
    to_cyc(5);
    chk("s1_if_done_c5", if_done, 1);
    chk("s1_if_rdata_c5", if_rdata, 16'h5A4A);
    chk("s1_if_stall_c5", if_stall, 0);
    if_req = 1'b0;
    to_cyc(6);

    // Store then load back.
    start_cycle0();
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'hBEEF;
    to_cyc(1);
    chk("s3_m_en_c1", m_en, 1);
    chk("s3_m_wr_c1", m_wr, 1);
    chk("s3_m_wdata_c1", m_wdata, 16'hBEEF);
    chk("s3_m_addr_c1", m_addr, 16'h0200);
    to_cyc(5);
    chk("s3_mem_done_c5", mem_done, 1);
    chk("s3_mem_rdata_kept", mem_rdata, 16'h5B5A);
    chk("s3_if_rdata_kept", if_rdata, 16'h5A4A);
    mem_req = 1'b0;
    to_cyc(6);
    start_cycle0();
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0200;
    to_cyc(1);
    chk("s3_ld_m_wr_c1", m_wr, 0);
    to_cyc(5);
    chk("s3_ld_done_c5", mem_done, 1);
    chk("s3_ld_rdata_c5", mem_rdata, 16'hBEEF);
    chk("s3_ld_if_rdata_kept", if_rdata, 16'h5A4A);
    mem_req = 1'b0;
    to_cyc(6);

    // Request address changes while busy.
    start_cycle0();
    if_req = 1'b1; if_addr = 16'h0010;
    to_cyc(2);
    if_addr = 16'h0020;
    to_cyc(3);
    chk("s5_m_addr_c3", m_addr, 16'h0010);
    to_cyc(5);
    chk("s5_if_done_c5", if_done, 1);
    chk("s5_if_rdata_c5", if_rdata, 16'h5A4A);
    if_req = 1'b0;
    to_cyc(6);

    // Reset in the middle of a fetch.
    start_cycle0();
    if_req = 1'b1; if_addr = 16'h0030;
    to_cyc(2);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_state", dbg_state, IDLE);
    chk("s4_rst_m_addr", m_addr, 0);
    chk("s4_rst_m_wdata", m_wdata, 0);
    chk("s4_rst_if_rdata", if_rdata, 0);
    chk("s4_rst_mem_rdata", mem_rdata, 0);
    chk("s4_rst_flags", {m_en, m_wr, if_done, mem_done}, 0);
`ifdef MEM_ARB_PERF_EN
    chk("s4_rst_perf", {perf_if_stall, perf_mem_stall} != 64'd0, 0);
`endif
    if_req = 1'b0;
    to_cyc(3);
    rst_n = 1'b1;
    start_cycle0();
    if_req = 1'b1; if_addr = 16'h0040;
    to_cyc(1);
    chk("s4_m_addr_c1", m_addr, 16'h0040);
    for (int c = 2; c <= 4; c++) begin
      to_cyc(c);
      chk("s4_no_stale_done", if_done, 0);
      chk("s4_no_stale_rdata", if_rdata, 0);
    end
    to_cyc(5);
    chk("s4_if_done_c5", if_done, 1);
    chk("s4_if_rdata_c5", if_rdata, 16'h5A1A);
    if_req = 1'b0;
    to_cyc(7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
